// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// No logic here, so no latency and no backpressure.
package hazard_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } hazState_t;

    // Operand-mux select encodings seen by the Execute stage.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // LOAD_LAT is at most 4, so the remaining-stall count never exceeds 3.
    localparam int STALL_CW = 2;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one Execute source register.
// Pure combinational, zero latency; no backpressure.
module fwd_sel
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              regWriteM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteW,
    output logic [1:0]        fwdSel
);

    logic hitM;
    logic hitW;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    assign hitM = regWriteM && (rdM != '0) && (rdM == rsE);
    assign hitW = regWriteW && (rdW != '0) && (rdW == rsE);

    // Memory stage holds the youngest result and wins over Writeback.
    always_comb begin
        fwdSel = FWD_RF;
        if (hitM) begin
            fwdSel = FWD_MEM;
        end else if (hitW) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall FSM, branch flush, perf counters.
// Controls are combinational in the same cycle; mem_busy freezes every stage and the FSM.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    input  logic              mem_busy,
    input  logic              cnt_clr,
    output logic [1:0]        forward_ae,
    output logic [1:0]        forward_be,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [STALL_CW-1:0] STALL_ONE  = STALL_CW'(1);
    localparam logic [STALL_CW-1:0] STALL_INIT = STALL_CW'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

    hazState_t           state;
    hazState_t           stateNxt;
    logic [STALL_CW-1:0] stallCnt;
    logic [STALL_CW-1:0] stallCntNxt;

    logic       loadUse;
    logic       branchFlush;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE;
    logic [1:0] fwdA, fwdB;

    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    fwd_sel #(.REG_AW(REG_AW)) u_fwdA (
        .rsE       (rs1_e),
        .rdM       (rd_m),
        .regWriteM (reg_write_m),
        .rdW       (rd_w),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdA)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwdB (
        .rsE       (rs2_e),
        .rdM       (rd_m),
        .regWriteM (reg_write_m),
        .rdW       (rd_w),
        .regWriteW (reg_write_w),
        .fwdSel    (fwdB)
    );

    assign loadUse     = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    // A branch seen under mem_busy waits until memory is ready; pc_src_e is held until then.
    assign branchFlush = pc_src_e && !mem_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stallCnt <= '0;
        end else begin
            state    <= stateNxt;
            stallCnt <= stallCntNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        stallCntNxt = stallCnt;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;

        if (mem_busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (pc_src_e) begin
            // The stalled consumer sits on the wrong path; drop the stall entirely.
            flushD      = 1'b1;
            flushE      = 1'b1;
            stateNxt    = IDLE;
            stallCntNxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadUse) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                        if (LOAD_LAT > 1) begin
                            stateNxt    = LSTALL;
                            stallCntNxt = STALL_INIT;
                        end
                    end
                end
                LSTALL: begin
                    stallF      = 1'b1;
                    stallD      = 1'b1;
                    flushE      = 1'b1;
                    stallCntNxt = stallCnt - STALL_ONE;
                    if (stallCnt <= STALL_ONE) begin
                        stateNxt    = IDLE;
                        stallCntNxt = '0;
                    end
                end
                default: begin
                    stateNxt    = IDLE;
                    stallCntNxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else if (cnt_clr) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (stallF && (stallCycles != '1)) begin
                stallCycles <= stallCycles + CNT_ONE;
            end
            if (branchFlush && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_ONE;
            end
        end
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign forward_ae   = rst ? fwdA : FWD_RF;
    assign forward_be   = rst ? fwdB : FWD_RF;
    assign stall_f      = rst && stallF;
    assign stall_d      = rst && stallD;
    assign stall_e      = rst && stallE;
    assign stall_m      = rst && stallM;
    assign flush_d      = rst && flushD;
    assign flush_e      = rst && flushE;
    assign stall_cycles = stallCycles;
    assign flush_count  = flushCount;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: dutA uses LOAD_LAT=1 / 32-bit counters, dutB uses LOAD_LAT=3 / 4-bit counters.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       loadE, regWriteM, regWriteW, pcSrcE, memBusy, cntClr;

    logic [1:0]  fwdAeA, fwdBeA, fwdAeB, fwdBeB;
    logic        sfA, sdA, seA, smA, fdA, feA;
    logic        sfB, sdB, seB, smB, fdB, feB;
    logic [31:0] scA, fcA;
    logic [3:0]  scB, fcB;
    logic [5:0]  ctlA, ctlB;

    int checks = 0;
    int errors = 0;

    // Control vector order: stall_f, stall_d, stall_e, stall_m, flush_d, flush_e
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110001;
    localparam logic [5:0] C_BUSY = 6'b111100;
    localparam logic [5:0] C_BR   = 6'b000011;

    assign ctlA = {sfA, sdA, seA, smA, fdA, feA};
    assign ctlB = {sfB, sdB, seB, smB, fdB, feB};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dutA (
        .clk(clk), .rst(rst),
        .rs1_d(rs1D), .rs2_d(rs2D), .rs1_e(rs1E), .rs2_e(rs2E), .rd_e(rdE), .load_e(loadE),
        .rd_m(rdM), .reg_write_m(regWriteM), .rd_w(rdW), .reg_write_w(regWriteW),
        .pc_src_e(pcSrcE), .mem_busy(memBusy), .cnt_clr(cntClr),
        .forward_ae(fwdAeA), .forward_be(fwdBeA),
        .stall_f(sfA), .stall_d(sdA), .stall_e(seA), .stall_m(smA),
        .flush_d(fdA), .flush_e(feA),
        .stall_cycles(scA), .flush_count(fcA)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst),
        .rs1_d(rs1D), .rs2_d(rs2D), .rs1_e(rs1E), .rs2_e(rs2E), .rd_e(rdE), .load_e(loadE),
        .rd_m(rdM), .reg_write_m(regWriteM), .rd_w(rdW), .reg_write_w(regWriteW),
        .pc_src_e(pcSrcE), .mem_busy(memBusy), .cnt_clr(cntClr),
        .forward_ae(fwdAeB), .forward_be(fwdBeB),
        .stall_f(sfB), .stall_d(sdB), .stall_e(seB), .stall_m(smB),
        .flush_d(fdB), .flush_e(feB),
        .stall_cycles(scB), .flush_count(fcB)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clrIn();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        loadE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        pcSrcE = 1'b0; memBusy = 1'b0; cntClr = 1'b0;
    endtask

    task automatic hazard();
        loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    endtask

    initial begin
        clrIn();
        // Reset held with every trigger active: outputs must stay quiet.
        rdM = 5'd5; regWriteM = 1'b1; rs1E = 5'd5; memBusy = 1'b1; pcSrcE = 1'b1;
        hazard();
        #2;
        chk("rst_fwdA", 32'(fwdAeA), 32'(FWD_RF));
        chk("rst_ctlA", 32'(ctlA), 32'(C_NONE));
        chk("rst_ctlB", 32'(ctlB), 32'(C_NONE));
        repeat (2) tick();
        chk("rst_scA", scA, 32'd0);
        chk("rst_fcA", fcA, 32'd0);
        chk("rst_scB", 32'(scB), 32'd0);
        clrIn();
        #1 rst = 1'b1;
        tick();

        // Forwarding priority and x0 exclusion
        rdM = 5'd5; regWriteM = 1'b1; rdW = 5'd5; regWriteW = 1'b1; rs1E = 5'd5; rs2E = 5'd3;
        #1 chk("fwd_mem", 32'(fwdAeA), 32'(2'b10));
        chk("fwd_none_b", 32'(fwdBeA), 32'(2'b00));
        rdM = 5'd0;
        #1 chk("fwd_wb", 32'(fwdAeA), 32'(2'b01));
        rs2E = 5'd5;
        #1 chk("fwd_wb_b", 32'(fwdBeA), 32'(2'b01));
        regWriteW = 1'b0;
        #1 chk("fwd_nowe", 32'(fwdAeA), 32'(2'b00));
        rdM = 5'd5; regWriteM = 1'b0; regWriteW = 1'b1; rdW = 5'd0; rs1E = 5'd0;
        #1 chk("fwd_x0", 32'(fwdAeA), 32'(2'b00));
        rdM = 5'd6; regWriteM = 1'b1; rs2E = 5'd6;
        #1 chk("fwd_mem_b", 32'(fwdBeB), 32'(2'b10));
        chk("fwd_noctl", 32'(ctlA), 32'(C_NONE));
        clrIn();

        // Load-use: one cycle for dutA, three for dutB
        tick();
        hazard();
        #1 chk("lu1_A", 32'(ctlA), 32'(C_LU));
        chk("lu1_B", 32'(ctlB), 32'(C_LU));
        tick();
        clrIn();
        #1 chk("lu2_A", 32'(ctlA), 32'(C_NONE));
        chk("lu2_B", 32'(ctlB), 32'(C_LU));
        chk("lu_scA", scA, 32'd1);
        tick();
        #1 chk("lu3_B", 32'(ctlB), 32'(C_LU));
        tick();
        #1 chk("lu4_B", 32'(ctlB), 32'(C_NONE));
        chk("lu_scB", 32'(scB), 32'd3);
        chk("lu_scA2", scA, 32'd1);
        loadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
        #1 chk("lu_x0", 32'(ctlA), 32'(C_NONE));
        clrIn();

        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        #1 chk("clr_scA", scA, 32'd0);
        chk("clr_scB", 32'(scB), 32'd0);

        // Branch in the second stall cycle squashes the stall
        loadE = 1'b1; rdE = 5'd9; rs1D = 5'd9;
        #1 chk("br_lu_B", 32'(ctlB), 32'(C_LU));
        tick();
        clrIn();
        pcSrcE = 1'b1;
        #1 chk("br_B", 32'(ctlB), 32'(C_BR));
        chk("br_A", 32'(ctlA), 32'(C_BR));
        tick();
        pcSrcE = 1'b0;
        #1 chk("br_idle_B", 32'(ctlB), 32'(C_NONE));
        chk("br_fcB", 32'(fcB), 32'd1);
        chk("br_fcA", fcA, 32'd1);
        chk("br_scB", 32'(scB), 32'd1);

        // mem_busy mid-stall freezes the remaining count
        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        hazard();
        #1 chk("frz_lu_B", 32'(ctlB), 32'(C_LU));
        tick();
        clrIn();
        memBusy = 1'b1;
        #1 chk("frz_busy1", 32'(ctlB), 32'(C_BUSY));
        tick();
        #1 chk("frz_busy2", 32'(ctlB), 32'(C_BUSY));
        tick();
        memBusy = 1'b0;
        #1 chk("frz_res1", 32'(ctlB), 32'(C_LU));
        tick();
        #1 chk("frz_res2", 32'(ctlB), 32'(C_LU));
        tick();
        #1 chk("frz_done", 32'(ctlB), 32'(C_NONE));
        chk("frz_scB", 32'(scB), 32'd5);
        chk("frz_scA", scA, 32'd3);

        // Branch deferred by four busy cycles during LSTALL
        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        hazard();
        #1;
        tick();
        clrIn();
        memBusy = 1'b1; pcSrcE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("dfr_busy", 32'(ctlB), 32'(C_BUSY));
            chk("dfr_busyA", 32'(ctlA), 32'(C_BUSY));
            chk("dfr_nofc", 32'(fcB), 32'd0);
            tick();
        end
        memBusy = 1'b0;
        #1 chk("dfr_br", 32'(ctlB), 32'(C_BR));
        tick();
        pcSrcE = 1'b0;
        #1 chk("dfr_idle", 32'(ctlB), 32'(C_NONE));
        chk("dfr_fcB", 32'(fcB), 32'd1);
        chk("dfr_scB", 32'(scB), 32'd5);
        chk("dfr_scA", scA, 32'd5);

        // Saturation of the 4-bit counter
        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        memBusy = 1'b1;
        repeat (16) tick();
        chk("sat_scB", 32'(scB), 32'd15);
        chk("sat_scA", scA, 32'd16);
        tick();
        chk("sat_hold", 32'(scB), 32'd15);

        // Asynchronous reset in the middle of LSTALL
        memBusy = 1'b0;
        hazard();
        #1 chk("ar_lu", 32'(ctlB), 32'(C_LU));
        tick();
        clrIn();
        #1 chk("ar_lstall", 32'(ctlB), 32'(C_LU));
        chk("ar_sat", 32'(scB), 32'd15);
        rst = 1'b0;
        #1 chk("ar_ctlB", 32'(ctlB), 32'(C_NONE));
        chk("ar_scB", 32'(scB), 32'd0);
        chk("ar_scA", scA, 32'd0);
        chk("ar_fcB", 32'(fcB), 32'd0);
        tick();
        rst = 1'b1;
        #1 chk("ar_rel", 32'(ctlB), 32'(C_NONE));
        tick();
        chk("ar_idle", 32'(ctlB), 32'(C_NONE));

        // Clear wins over a same-cycle increment
        memBusy = 1'b1;
        tick();
        chk("cc_pre", 32'(scB), 32'd1);
        cntClr = 1'b1;
        tick();
        chk("cc_scB", 32'(scB), 32'd0);
        chk("cc_scA", scA, 32'd0);
        clrIn();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_LAT, default 1, load-use stall cycles (legal 1..4).
REQ-003 Parameter CNT_W, default 32, performance-counter width.
REQ-004 Ports, one per line:
  clk  input  1  clock, rising-edge
  rst  input  1  reset, asynchronous, active-low
  rs1_d, rs2_d  input  REG_AW  source addresses of instruction in Decode
  rs1_e, rs2_e  input  REG_AW  source addresses of instruction in Execute
  rd_e  input  REG_AW  destination in Execute
  load_e  input  1  Execute instruction is a load (ResultSrcE==01)
  rd_m, reg_write_m  input  REG_AW, 1  Memory-stage destination / write enable
  rd_w, reg_write_w  input  REG_AW, 1  Writeback-stage destination / write enable
  pc_src_e  input  1  taken branch/jump resolved in Execute
  mem_busy  input  1  data memory not ready; pipeline must freeze
  cnt_clr  input  1  synchronous clear of performance counters
  forward_ae, forward_be  output  2  operand-mux selects: 00 regfile, 01 Writeback, 10 Memory
  stall_f, stall_d, stall_e, stall_m  output  1  hold stage register
  flush_d, flush_e  output  1  clear stage register to bubble
  stall_cycles  output  CNT_W  count of cycles with stall_f high
  flush_count  output  CNT_W  count of branch flush events

Function
REQ-005 forward_ae SHALL be 10 when reg_write_m, rd_m!=0, rd_m==rs1_e; else 01 when reg_write_w, rd_w!=0, rd_w==rs1_e; else 00 (combinational); forward_be identical on rs2_e.
REQ-006 Load-use hazard SHALL be load_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
REQ-007 FSM states IDLE, LSTALL; a 2-bit-min down-counter holds remaining stall cycles.
REQ-008 IDLE: on hazard, assert stall_f, stall_d, flush_e that cycle; if LOAD_LAT>1 go LSTALL with counter=LOAD_LAT-1, else stay IDLE.
REQ-009 LSTALL: assert stall_f, stall_d, flush_e; decrement counter; return IDLE after counter reaches 1.
REQ-010 pc_src_e (mem_busy low) SHALL assert flush_d and flush_e, deassert stall_f/stall_d, and force FSM to IDLE next cycle (squashed load-use consumer).
REQ-011 mem_busy SHALL have top priority: stall_f, stall_d, stall_e, stall_m all high; flush_d, flush_e low; FSM state and counter frozen.
REQ-012 stall_e and stall_m SHALL be high only under mem_busy.
REQ-013 Branch while mem_busy SHALL be deferred; flush occurs in first cycle mem_busy is low with pc_src_e still high.
REQ-014 stall_cycles SHALL increment every cycle stall_f is high; flush_count every cycle REQ-010 flush applies; both saturate at all-ones.
REQ-015 cnt_clr SHALL zero both counters next edge, overriding increment that cycle.

Reset
REQ-016 While rst low: FSM IDLE, counter 0, stall_cycles and flush_count 0, all stall/flush outputs 0, forward_ae/forward_be 00.
REQ-017 Reset asserted mid-LSTALL SHALL abort the stall immediately (asynchronous); first cycle after release evaluates from IDLE.

Structure
REQ-018 Shared package SHALL hold FSM state typedef and forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
REQ-019 Forwarding logic SHALL be one sub-module fwd_sel, instantiated twice (rs1_e, rs2_e); FSM and counters in hazard_ctrl.

Verification
REQ-020 rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_ae=10; rd_m=0 same case -> forward_ae=01.
REQ-021 LOAD_LAT=1, load_e=1, rd_e=7, rs2_d=7 -> stall_f, stall_d, flush_e high exactly 1 cycle; stall_cycles=1.
REQ-022 LOAD_LAT=3, same hazard -> stalls 3 consecutive cycles, then IDLE; stall_cycles=3.
REQ-023 LOAD_LAT=3, pc_src_e=1 in second stall cycle -> flush_d, flush_e high, stall_f low that cycle, FSM IDLE next; flush_count=1.
REQ-024 mem_busy high 4 cycles during LSTALL with pc_src_e=1 -> all four stalls high, no flush; after release flush occurs once; stall_cycles includes the 4 busy cycles.
REQ-025 rst pulled low mid-LSTALL, counters preloaded near all-ones -> all outputs 0 immediately; separately, counter at all-ones stays saturated; cnt_clr -> 0 next cycle.
